// File: rtl/toggle_debounce.sv
// Push-button conditioner: 2-flop sync, debounce counter, press/release FSM.
// Define TOGGLE_DEBOUNCE_AUTOREPEAT_EN to emit repeat pulses while held.
module toggle_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       t,
  output logic       pressed,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic          r_q1;
  logic          r_q2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_t;
  logic          w_t_nxt;
  logic          r_pressed;
  logic          w_pressed_nxt;
  logic          w_s;

  assign w_s       = r_q2;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef TOGGLE_DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_rep_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_rep <= '0;
    else       r_rep <= w_rep_nxt;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_CYCLES > 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q1      <= 1'b0;
      r_q2      <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_t       <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_q1      <= btn_in;
      r_q2      <= r_q1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_t       <= w_t_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_t_nxt     = 1'b0;
`ifdef TOGGLE_DEBOUNCE_AUTOREPEAT_EN
    w_rep_nxt   = r_rep;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = PRESSED;
          w_t_nxt     = 1'b1;
`ifdef TOGGLE_DEBOUNCE_AUTOREPEAT_EN
          w_rep_nxt   = '0;
`endif
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else begin
`ifdef TOGGLE_DEBOUNCE_AUTOREPEAT_EN
          // Held: count stay cycles, fire and restart at the period.
          if (r_rep == R_LAST) begin
            w_t_nxt   = 1'b1;
            w_rep_nxt = '0;
          end else begin
            w_rep_nxt = r_rep + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
`ifdef TOGGLE_DEBOUNCE_AUTOREPEAT_EN
          w_rep_nxt   = '0;
`endif
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_pressed_nxt = (w_state_nxt == PRESSED) ||
                    (w_state_nxt == RELEASE_WAIT);
  end

  assign t       = r_t;
  assign pressed = r_pressed;
  assign state_o = r_state;

endmodule

// File: tb/tb_toggle_debounce.sv
// Bench for toggle_debounce: DEBOUNCE_CYCLES=4 and =1 instances
// against a run-length model of the debounced level.
module tb_toggle_debounce;

`ifdef TOGGLE_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int RPT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       t4, p4, t1, p1;
  logic [1:0] s4, s1;

  int tests = 0;
  int fails = 0;

  int dcy [2] = '{4, 1};
  int lvl [2];
  int run [2];
  int rep [2];
  int et  [2];
  int q1m, q2m;

  always #5 clk = ~clk;

  toggle_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(RPT)) u_d4 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .t(t4), .pressed(p4), .state_o(s4)
  );

  toggle_debounce #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(RPT)) u_d1 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .t(t1), .pressed(p1), .state_o(s1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Level flips after D+1 consecutive synchronized samples that differ.
  task automatic model_edge(input logic b, input logic r);
    int s;
    if (r) begin
      q1m = 0;
      q2m = 0;
      for (int i = 0; i < 2; i++) begin
        lvl[i] = 0; run[i] = 0; rep[i] = 0; et[i] = 0;
      end
    end else begin
      s   = q2m;
      q2m = q1m;
      q1m = int'(b);
      for (int i = 0; i < 2; i++) begin
        et[i] = 0;
        if (s != lvl[i]) begin
          run[i]++;
          if (run[i] == dcy[i] + 1) begin
            lvl[i] = s;
            run[i] = 0;
            rep[i] = 0;
            if (s == 1) et[i] = 1;
          end
        end else begin
          if (lvl[i] == 1) begin
            if (run[i] > 0) rep[i] = 0;
            else if (AR) begin
              rep[i]++;
              if (rep[i] == RPT) begin
                et[i] = 1;
                rep[i] = 0;
              end
            end
          end
          run[i] = 0;
        end
      end
    end
  endtask

  function automatic int exp_state(input int i);
    if (lvl[i] == 1) return (run[i] > 0) ? 3 : 2;
    return (run[i] > 0) ? 1 : 0;
  endfunction

  task automatic step(input logic b, input logic r);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    check("d4_t", int'(t4), et[0]);
    check("d4_pressed", int'(p4), lvl[0]);
    check("d4_state", int'(s4), exp_state(0));
    check("d1_t", int'(t1), et[1]);
    check("d1_pressed", int'(p1), lvl[1]);
    check("d1_state", int'(s1), exp_state(1));
  endtask

  task automatic hold(input logic b, input int n);
    for (int k = 0; k < n; k++) step(b, 1'b0);
  endtask

  initial begin
    int len;
    logic b;
    // Reset held 3 cycles with button pressed
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    // Held after reset: clean press
    hold(1'b1, 20);
    hold(1'b0, 10);
    // Bounce then stable high
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    hold(1'b1, 14);
    // Release glitch while pressed
    hold(1'b0, 2);
    hold(1'b1, 8);
    hold(1'b0, 10);
    // Reset in PRESS_WAIT with cnt=2, button still held
    hold(1'b1, 5);
    step(1'b1, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Long hold (auto-repeat window)
    hold(1'b1, 40);
    hold(1'b0, 10);
    // Random runs of random length, occasional reset
    for (int n = 0; n < 120; n++) begin
      b   = logic'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int k = 0; k < len; k++)
        step(b, ($urandom_range(0, 63) == 0));
    end
    hold(1'b0, 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
